// File: rtl/rice_core_pipeline_controller.sv
// Pipeline controller: stall / flush / EX-bubble generation for the IF/ID/EX
// pipeline, load-use hazard detection, memory-wait hold with deferred
// redirects, and a saturating stall-cycle performance counter.
module rice_core_pipeline_controller #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  input  logic                 i_id_valid,
  input  logic [4:0]           i_id_rs1,
  input  logic [4:0]           i_id_rs2,
  input  logic                 i_ex_valid,
  input  logic [4:0]           i_ex_rd,
  input  logic                 i_ex_load,
  input  logic                 i_redirect,
  input  logic                 i_mem_busy,
  output logic                 o_stall,
  output logic                 o_flush,
  output logic                 o_ex_bubble,
  output logic [1:0]           o_state,
  output logic [CNT_WIDTH-1:0] o_stall_cycles
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  // Counter only needs to hold FLUSH_CYCLES-1.
  localparam int            CW     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(FLUSH_CYCLES - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 pending_q, pending_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic                 load_use;

  assign load_use = i_id_valid & i_ex_valid & i_ex_load & (i_ex_rd != 5'd0) &
                    ((i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2));

  // Next-state and output decode; outputs depend on current inputs so a
  // stall or flush acts in the same cycle it is detected.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pending_d   = pending_q;
    o_stall     = 1'b0;
    o_flush     = 1'b0;
    o_ex_bubble = 1'b0;
    if (!i_enable) begin
      o_flush   = 1'b1;
      state_d   = IDLE;
      pending_d = 1'b0;
      cnt_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          o_flush = 1'b1;
          state_d = RUN;
        end
        RUN: begin
          if (i_mem_busy) begin
            o_stall = 1'b1;
            if (i_redirect) pending_d = 1'b1;
            state_d = MEM_WAIT;
          end else if (i_redirect) begin
            o_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              cnt_d   = RELOAD;
              state_d = FLUSH;
            end
          end else if (load_use) begin
            o_stall     = 1'b1;
            o_ex_bubble = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (i_mem_busy) begin
            o_stall = 1'b1;
            if (i_redirect) pending_d = 1'b1;
          end else if (pending_q || i_redirect) begin
            // Deferred redirect lands on the release cycle.
            o_flush   = 1'b1;
            pending_d = 1'b0;
            if (FLUSH_CYCLES > 1) begin
              cnt_d   = RELOAD;
              state_d = FLUSH;
            end else begin
              state_d = RUN;
            end
          end else begin
            if (load_use) begin
              o_stall     = 1'b1;
              o_ex_bubble = 1'b1;
            end
            state_d = RUN;
          end
        end
        FLUSH: begin
          // Memory cannot be busy here, so i_mem_busy is not consulted.
          o_flush     = 1'b1;
          o_ex_bubble = 1'b1;
          if (i_redirect) begin
            cnt_d = RELOAD;
          end else if (cnt_q == ONE) begin
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Saturating stall-cycle counter; survives i_enable=0.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (o_stall && (stall_cnt_q != {CNT_WIDTH{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_state        = state_q;
  assign o_stall_cycles = stall_cnt_q;

endmodule
